// File: rtl/display_scan_counter.sv
// Row/column scan position counter for a ROWS x COLS display frame.
// Steps up or down on column/row requests, wraps or halts at frame end, and flags line/frame completion.
module display_scan_counter #(
    parameter int ROWS  = 21,
    parameter int COLS  = 32,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_add_col,
    input  logic             i_add_row,
    input  logic             i_dir,
    input  logic             i_sat,
    input  logic             i_load,
    input  logic [ROW_W-1:0] i_load_row,
    input  logic [COL_W-1:0] i_load_col,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_line_done,
    output logic             o_frame_done,
    output logic             o_halted
);

    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [ROW_W-1:0] row_r;
    logic [ROW_W-1:0] row_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_s;
    logic             line_done_r;
    logic             line_done_s;
    logic             frame_done_r;
    logic             frame_done_s;

    logic [COL_W-1:0] col_start_s;
    logic [COL_W-1:0] col_end_s;
    logic             at_frame_edge_s;
    logic             row_step_s;

    // Direction-dependent line start/end and the frame-edge row for the next step
    always_comb begin
        col_start_s     = COL_ZERO;
        col_end_s       = COL_MAX;
        at_frame_edge_s = 1'b0;
        if (i_dir) begin
            col_start_s     = COL_MAX;
            col_end_s       = COL_ZERO;
            at_frame_edge_s = (row_r == ROW_ZERO);
        end else begin
            col_start_s     = COL_ZERO;
            col_end_s       = COL_MAX;
            at_frame_edge_s = (row_r == ROW_MAX);
        end
        row_step_s = i_add_row || (i_add_col && (col_r == col_end_s));
    end

    // Next-state, next-position and pulse logic; priority load > hold > row > col
    always_comb begin
        state_s      = state_r;
        row_s        = row_r;
        col_s        = col_r;
        line_done_s  = 1'b0;
        frame_done_s = 1'b0;
        if (i_load) begin
            row_s   = (i_load_row > ROW_MAX) ? ROW_MAX : i_load_row;
            col_s   = (i_load_col > COL_MAX) ? COL_MAX : i_load_col;
            state_s = RUN;
        end else if (!i_en || (state_r == HALT)) begin
            state_s = state_r;
        end else if (row_step_s) begin
            line_done_s = 1'b1;
            if (at_frame_edge_s) begin
                frame_done_s = 1'b1;
                if (i_sat) begin
                    // Park on the frame end instead of wrapping
                    row_s   = i_dir ? ROW_ZERO : ROW_MAX;
                    col_s   = col_end_s;
                    state_s = HALT;
                end else begin
                    row_s = i_dir ? ROW_MAX : ROW_ZERO;
                    col_s = col_start_s;
                end
            end else begin
                row_s = i_dir ? (row_r - ROW_ONE) : (row_r + ROW_ONE);
                col_s = col_start_s;
            end
        end else if (i_add_col) begin
            col_s = i_dir ? (col_r - COL_ONE) : (col_r + COL_ONE);
        end else begin
            state_s = state_r;
        end
    end

    // State, position and pulse registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= RUN;
            row_r        <= ROW_ZERO;
            col_r        <= COL_ZERO;
            line_done_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            row_r        <= row_s;
            col_r        <= col_s;
            line_done_r  <= line_done_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign o_row        = row_r;
    assign o_col        = col_r;
    assign o_line_done  = line_done_r;
    assign o_frame_done = frame_done_r;
    assign o_halted     = (state_r == HALT);

endmodule

// File: tb/tb_display_scan_counter.sv
// Directed self-checking bench for display_scan_counter with ROWS=21, COLS=4.
module tb_display_scan_counter;

    localparam int ROWS  = 21;
    localparam int COLS  = 4;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             add_col;
    logic             add_row;
    logic             dir;
    logic             sat;
    logic             load;
    logic [ROW_W-1:0] load_row;
    logic [COL_W-1:0] load_col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             line_done;
    logic             frame_done;
    logic             halted;

    int checks = 0;
    int fails  = 0;

    logic [ROW_W+COL_W+2:0] obs;
    logic [ROW_W+COL_W+2:0] exp_v;
    assign obs = {row, col, line_done, frame_done, halted};

    display_scan_counter #(.ROWS(ROWS), .COLS(COLS)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_add_col(add_col), .i_add_row(add_row),
        .i_dir(dir), .i_sat(sat), .i_load(load), .i_load_row(load_row), .i_load_col(load_col),
        .o_row(row), .o_col(col), .o_line_done(line_done), .o_frame_done(frame_done),
        .o_halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [ROW_W+COL_W+2:0] pack(input int r, input int c,
                                                    input logic ld, input logic fd, input logic h);
        pack = {ROW_W'(r), COL_W'(c), ld, fd, h};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; add_col = 1'b0; add_row = 1'b0; load = 1'b0;
        load_row = '0; load_col = '0;
    endtask

    task automatic do_load(input int r, input int c);
        load = 1'b1; load_row = ROW_W'(r); load_col = COL_W'(c);
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); dir = 1'b0; sat = 1'b0;
        #1;
        exp_v = pack(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_async got %h want %h", obs, exp_v); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL reset_release got %h want %h", obs, exp_v); end
    endtask

    task automatic test_up_count();
        dir = 1'b0; sat = 1'b0; add_col = 1'b1;
        for (int k = 1; k <= 84; k++) begin
            tick();
            exp_v = pack((k / 4) % 21, k % 4, (k % 4) == 0, k == 84, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                fails++; $display("FAIL up_count step %0d got %h want %h", k, obs, exp_v);
            end
            if (k == 83) begin
                checks++;
                if ({row, col} !== {5'd20, 2'd3}) begin
                    fails++; $display("FAIL up_count_pos83 got (%0d,%0d) want (20,3)", row, col);
                end
            end
        end
        add_col = 1'b0;
        checks++;
        if ({row, col} !== {5'd0, 2'd0}) begin
            fails++; $display("FAIL up_count_final got (%0d,%0d) want (0,0)", row, col);
        end
        tick();
        exp_v = pack(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL up_count_idle got %h want %h", obs, exp_v); end
    endtask

    task automatic test_row_jump();
        dir = 1'b0; sat = 1'b0;
        do_load(5, 2);
        exp_v = pack(5, 2, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL row_jump_load got %h want %h", obs, exp_v); end
        add_row = 1'b1; add_col = 1'b1;
        tick();
        add_row = 1'b0; add_col = 1'b0;
        exp_v = pack(6, 0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL row_jump got %h want %h", obs, exp_v); end
        tick();
        exp_v = pack(6, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL row_jump_pulse_drop got %h want %h", obs, exp_v); end
    endtask

    task automatic test_saturate_up();
        dir = 1'b0; sat = 1'b1;
        do_load(20, 2);
        add_col = 1'b1;
        tick();
        exp_v = pack(20, 3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL sat_step1 got %h want %h", obs, exp_v); end
        tick();
        exp_v = pack(20, 3, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL sat_step2 got %h want %h", obs, exp_v); end
        tick();
        exp_v = pack(20, 3, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL sat_step3 got %h want %h", obs, exp_v); end
        add_col = 1'b0; add_row = 1'b1;
        tick();
        add_row = 1'b0;
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL sat_row_ignored got %h want %h", obs, exp_v); end
        do_load(0, 0);
        exp_v = pack(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL sat_unhalt got %h want %h", obs, exp_v); end
        sat = 1'b0;
    endtask

    task automatic test_down_wrap();
        rst = 1'b1; idle_inputs();
        tick();
        rst = 1'b0; dir = 1'b1; sat = 1'b0;
        tick();
        add_col = 1'b1;
        tick();
        exp_v = pack(20, 3, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL down_wrap got %h want %h", obs, exp_v); end
        tick();
        exp_v = pack(20, 2, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL down_back_to_back got %h want %h", obs, exp_v); end
        // Direction flip mid-line steps from the current position
        dir = 1'b0;
        tick();
        add_col = 1'b0;
        exp_v = pack(20, 3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL dir_flip got %h want %h", obs, exp_v); end
    endtask

    task automatic test_hold();
        dir = 1'b0; sat = 1'b0;
        do_load(3, 3);
        add_col = 1'b1;
        tick();
        exp_v = pack(4, 0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL hold_pre got %h want %h", obs, exp_v); end
        en = 1'b0;
        tick(); tick();
        exp_v = pack(4, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL hold got %h want %h", obs, exp_v); end
        en = 1'b1; add_col = 1'b0;
    endtask

    task automatic test_load_clamp();
        dir = 1'b0; sat = 1'b0;
        load = 1'b1; load_row = ROW_W'(31); load_col = COL_W'(7); add_col = 1'b1;
        tick();
        load = 1'b0; add_col = 1'b0;
        exp_v = pack(20, 3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL load_clamp got %h want %h", obs, exp_v); end
        do_load(21, 1);
        exp_v = pack(20, 1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL load_clamp_21 got %h want %h", obs, exp_v); end
    endtask

    task automatic test_async_reset();
        dir = 1'b0; sat = 1'b0;
        do_load(12, 1);
        exp_v = pack(12, 1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL areset_pre got %h want %h", obs, exp_v); end
        #2;
        rst = 1'b1;
        #1;
        exp_v = pack(0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL areset_mid got %h want %h", obs, exp_v); end
        tick();
        rst = 1'b0; add_col = 1'b1;
        tick();
        add_col = 1'b0;
        exp_v = pack(0, 1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v) begin fails++; $display("FAIL areset_first_step got %h want %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_row_jump();
        test_saturate_up();
        test_down_wrap();
        test_hold();
        test_load_clamp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
